// File: rtl/vga_scan_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_scan_gen
//  Brief    : Raster scan generator (640x480@60 default) with registered,
//             mutually aligned coordinate, sync, blanking and tick outputs.
//  Revision : 1.0
// ============================================================================
module vga_scan_gen #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic        clk,
    input  logic        BTN_S,
    output logic [10:0] visible_col,
    output logic [10:0] visible_row,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic        pix_tick,
    output logic        frame_tick
);

    localparam int c_H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int c_DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_ONE  = c_DIV_W'(1);
    localparam logic [10:0]        c_ONE      = 11'd1;
    localparam logic [10:0]        c_H_LAST   = 11'(c_H_TOTAL - 1);
    localparam logic [10:0]        c_V_LAST   = 11'(c_V_TOTAL - 1);
    localparam logic [10:0]        c_H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0]        c_V_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0]        c_HS_BEG   = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0]        c_HS_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [10:0]        c_VS_BEG   = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0]        c_VS_END   = 11'(V_VISIBLE + V_FP + V_SYNC);

    logic [c_DIV_W-1:0] r_div_cnt;
    logic [c_DIV_W-1:0] w_div_nxt;
    logic [10:0]        w_h_nxt;
    logic [10:0]        w_v_nxt;

    // Next-state counters; the registered outputs are decoded from these so
    // sync/blank always describe the coordinate shown in the same cycle.
    always_comb begin
        w_div_nxt = (r_div_cnt == c_DIV_LAST) ? '0 : r_div_cnt + c_DIV_ONE;
        w_h_nxt   = visible_col;
        w_v_nxt   = visible_row;
        if (pix_tick) begin
            if (visible_col == c_H_LAST) begin
                w_h_nxt = '0;
                w_v_nxt = (visible_row == c_V_LAST) ? 11'd0 : visible_row + c_ONE;
            end else begin
                w_h_nxt = visible_col + c_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!BTN_S) begin
            r_div_cnt   <= '0;
            visible_col <= '0;
            visible_row <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b0;
            pix_tick    <= 1'b0;
            frame_tick  <= 1'b0;
        end else begin
            r_div_cnt   <= w_div_nxt;
            visible_col <= w_h_nxt;
            visible_row <= w_v_nxt;
            hsync       <= !((w_h_nxt >= c_HS_BEG) && (w_h_nxt < c_HS_END));
            vsync       <= !((w_v_nxt >= c_VS_BEG) && (w_v_nxt < c_VS_END));
            video_on    <= (w_h_nxt < c_H_VIS) && (w_v_nxt < c_V_VIS);
            pix_tick    <= (w_div_nxt == c_DIV_LAST);
            frame_tick  <= (w_div_nxt == c_DIV_LAST) && (w_h_nxt == c_H_LAST)
                           && (w_v_nxt == c_V_LAST);
        end
    end

endmodule
`default_nettype wire

// File: doc/vga_scan_gen.md
Name: vga_scan_gen

Overview:
- Raster scan generator that sits directly upstream of the ball/shape pixel-test stages.
- Produces the current pixel coordinate (visible_col, visible_row), the sync pulses and the blanking qualifier for a 640x480@60 Hz VGA display.
- Also produces a one-cycle end-of-frame pulse that downstream position logic (ball centre col/row updates) uses as its frame-rate tick.
- Every output is registered, so all outputs are mutually aligned in the same clk cycle.

Parameters:
- CLK_DIV, 2, number of clk cycles per pixel (board 50 MHz to pixel 25 MHz); legal values are 1 or more.
- H_VISIBLE, 640, active pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, hsync pulse width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_VISIBLE, 480, active lines per frame.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vsync pulse width in lines.
- V_BP, 33, vertical back porch in lines.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- BTN_S  in  1  reset, synchronous, active-low.
- visible_col  out  11  horizontal counter h_cnt, range 0..H_TOTAL-1.
- visible_row  out  11  vertical counter v_cnt, range 0..V_TOTAL-1.
- hsync  out  1  horizontal sync, active-low.
- vsync  out  1  vertical sync, active-low.
- video_on  out  1  high when h_cnt < H_VISIBLE and v_cnt < V_VISIBLE.
- pix_tick  out  1  high in the clk cycle in which the counters advance at the next edge.
- frame_tick  out  1  one-cycle pulse on the last pixel of the frame.

Behaviour:
- Derived constants: H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (default 525).
- Reset (BTN_S=0 sampled at a rising clk edge):
  - div_cnt, h_cnt and v_cnt go to 0.
  - hsync=1, vsync=1, video_on=0, pix_tick=0, frame_tick=0.
  - Reset has priority over every other event, including mid-line, mid-sync and the frame wrap.
- Pixel divider:
  - div_cnt counts 0..CLK_DIV-1 and then wraps.
  - pix_tick is a registered output, high exactly when div_cnt == CLK_DIV-1.
  - CLK_DIV=1: pix_tick is high every cycle from the first edge after reset release.
- Horizontal counter: on an edge with pix_tick=1, h_cnt increments; from H_TOTAL-1 it wraps to 0.
- Vertical counter: v_cnt increments only when h_cnt wraps; from V_TOTAL-1 it wraps to 0. With pix_tick=0 both counters hold.
- Decode alignment: hsync, vsync and video_on are registered from the next-state counter values. They therefore always describe the {visible_col, visible_row} presented in the same cycle. This is zero relative latency, so downstream combinational pixel tests stay aligned.
- Sync windows:
  - hsync=0 iff H_VISIBLE+H_FP <= h_cnt < H_VISIBLE+H_FP+H_SYNC (default 656..751).
  - vsync=0 iff V_VISIBLE+V_FP <= v_cnt < V_VISIBLE+V_FP+V_SYNC (default 490..491).
- First cycle after reset release: counters read (0,0) with video_on=1, hsync=1, vsync=1.
- frame_tick is high in exactly one clk cycle per frame: the cycle where h_cnt==H_TOTAL-1, v_cnt==V_TOTAL-1 and pix_tick=1. It is never asserted during reset.
- Counter width: 11 bits is enough for every parameter set with H_TOTAL, V_TOTAL <= 2047. Counters never exceed TOTAL-1.

Test Plan:
- Reset: hold BTN_S=0 for 5 cycles at arbitrary prior state -> visible_col=0, visible_row=0, hsync=1, vsync=1, video_on=0, pix_tick=0, frame_tick=0. Release -> next cycle (0,0) with video_on=1.
- Line timing (defaults): over one line, pix_tick pulses every 2 clk.
  - video_on falls at the transition h 639->640.
  - hsync falls at h=656 and rises at h=752.
  - visible_col wraps 799->0 and visible_row increments by 1 in the same cycle.
- Frame timing: vsync low exactly for rows 490 and 491 (1600 pix_ticks). frame_tick pulses once every 840000 clk cycles (800*525*2), coinciding with (799,524).
- Reset mid-sync: assert BTN_S=0 at h=700, v=491 -> next cycle counters are 0 and hsync=vsync=1. After release, the first frame_tick occurs 840000 cycles later.
- CLK_DIV=1 variant: pix_tick constantly 1 after release; frame period is 420000 clk cycles; sync windows are unchanged in pixel units.
- Alignment check: in every cycle, hsync, vsync and video_on equal a reference decode of the visible_col/visible_row shown in that same cycle, across 2 full frames.
